// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice.
//   fetch_state_t : FETCH / WAIT_SLOT / HALTED
//   instr_word_t  : big-endian instruction word as it leaves memory
//   INSTR_BYTES   : bytes per instruction (also the PC stride)
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int BYTE_IDX_W  = 2;
  // rsrc2 shares the upper nibble of the immediate field
  localparam int RSRC2_LSB   = 12;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_SLOT = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]  opcode;     // word[31:24]
    logic [3:0]  rdest;      // word[23:20]
    logic [3:0]  rsrc1;      // word[19:16]
    logic [15:0] rsrc2_imm;  // word[15:0], rsrc2 = [15:12]
  } instr_word_t;

endpackage

// File: rtl/fetch_out_buffer.sv
// One-entry valid/ready holding register for an assembled instruction
// and the address of its first byte.
//   load/load_word/load_pc : write a new entry (wins over consume)
//   flush                  : drop the entry (redirect)
//   out_ready              : downstream consumes the entry when out_valid
//   out_valid/out_word/out_pc : held stable until consumed
module fetch_out_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  instr_word_t           load_word,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  input  logic                  out_ready,
  output logic                  out_valid,
  output instr_word_t           out_word,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  logic                  valid_q, valid_d;
  instr_word_t           word_q, word_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      word_d  = load_word;
      pc_d    = load_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch. Reads four bytes per instruction from
// pc..pc+3 (big-endian, byte at pc is the opcode), assembles the word and
// hands it to the control unit through a one-entry output slot.
//   clk, rst            : clock, synchronous active-high reset
//   mem_*               : byte read port (req held until ack)
//   redirect_valid/_pc  : jump from execute, discards partial word and slot
//   halt / halted       : stop fetching permanently (until rst)
//   instr_*             : decoded fields with valid/ready handshake
// Optional: define FETCH_PERF_COUNTERS_EN to add perf_instr_count and
// perf_stall_count (saturating 32-bit counters).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [3:0]            instr_rdest,
  output logic [3:0]            instr_rsrc1,
  output logic [3:0]            instr_rsrc2,
  output logic [15:0]           instr_imm,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_instr_count,
  output logic [31:0]           perf_stall_count
`endif
);

  fetch_state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]           pc_q, pc_d;
  logic [BYTE_IDX_W-1:0]           byte_idx_q, byte_idx_d;
  logic [INSTR_BYTES-1:0][7:0]     asm_q, asm_d;

  logic                  slot_valid, slot_load, slot_flush;
  instr_word_t           slot_word;
  logic [ADDR_WIDTH-1:0] slot_pc;
  logic                  ack_ok, slot_free;

  // Halt and redirect pre-empt the bus this cycle, so any ack is dropped.
  assign mem_req   = !rst && (state_q == FETCH) && !halt && !redirect_valid;
  assign mem_addr  = pc_q + ADDR_WIDTH'(byte_idx_q);
  assign ack_ok    = mem_req && mem_ack;
  assign slot_free = !slot_valid || instr_ready;
  assign halted    = (state_q == HALTED);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;
    if (halt) begin
      state_d    = HALTED;
      byte_idx_d = '0;
    end else if (redirect_valid && state_q != HALTED) begin
      state_d    = FETCH;
      pc_d       = redirect_pc;
      byte_idx_d = '0;
      slot_flush = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack_ok) begin
            // byte_idx 0 lands in the most significant byte
            asm_d[INSTR_BYTES-1-int'(byte_idx_q)] = mem_rdata;
            byte_idx_d = byte_idx_q + 1'b1;
            if (byte_idx_q == BYTE_IDX_W'(INSTR_BYTES - 1)) begin
              byte_idx_d = '0;
              if (slot_free) begin
                slot_load = 1'b1;
                pc_d      = pc_q + ADDR_WIDTH'(INSTR_BYTES);
              end else begin
                state_d = WAIT_SLOT;
              end
            end
          end
        end
        WAIT_SLOT: begin
          if (slot_valid && instr_ready) begin
            slot_load = 1'b1;
            pc_d      = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            state_d   = FETCH;
          end
        end
        HALTED: ;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      byte_idx_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
    end
  end

  fetch_out_buffer #(.ADDR_WIDTH(ADDR_WIDTH)) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .flush     (slot_flush),
    .load_word (instr_word_t'(asm_d)),
    .load_pc   (pc_q),
    .out_ready (instr_ready),
    .out_valid (slot_valid),
    .out_word  (slot_word),
    .out_pc    (slot_pc)
  );

  assign instr_valid  = slot_valid;
  assign instr_opcode = slot_word.opcode;
  assign instr_rdest  = slot_word.rdest;
  assign instr_rsrc1  = slot_word.rsrc1;
  assign instr_rsrc2  = slot_word.rsrc2_imm[RSRC2_LSB +: 4];
  assign instr_imm    = slot_word.rsrc2_imm;
  assign instr_pc     = slot_pc;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_stall_d = perf_stall_q;
    if (slot_load && perf_instr_q != '1)
      perf_instr_d = perf_instr_q + 32'd1;
    if (((mem_req && !mem_ack) || state_q == WAIT_SLOT) && perf_stall_q != '1)
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr_count = perf_instr_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_valid, instr_ready;
  logic [7:0]  instr_opcode;
  logic [3:0]  instr_rdest, instr_rsrc1, instr_rsrc2;
  logic [15:0] instr_imm, instr_pc;
  logic        halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_instr_count, perf_stall_count;
  logic [31:0] perf_instr_count_w, perf_stall_count_w;
`endif

  // second instance for the address wrap case
  logic        mem_req_w, mem_ack_w;
  logic [15:0] mem_addr_w;
  logic [7:0]  mem_rdata_w;
  logic        redirect_valid_w = 1'b0;
  logic [15:0] redirect_pc_w = 16'h0;
  logic        halt_w = 1'b0;
  logic        instr_ready_w = 1'b1;
  logic        instr_valid_w, halted_w;
  logic [7:0]  instr_opcode_w;
  logic [3:0]  instr_rdest_w, instr_rsrc1_w, instr_rsrc2_w;
  logic [15:0] instr_imm_w, instr_pc_w;

  int checks = 0;
  int errors = 0;

  // memory model: ack after ack_lat idle cycles of a held request
  logic [7:0] mem [0:255];
  int   ack_lat;
  logic ack_en, force_ack;
  int   wait_cnt;
  always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
  assign mem_ack   = force_ack | (ack_en & mem_req & (wait_cnt >= ack_lat));
  assign mem_rdata = mem[mem_addr[7:0]];

  assign mem_ack_w   = mem_req_w;
  assign mem_rdata_w = mem_addr_w[7:0] ^ 8'h5A;

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rdest(instr_rdest),
    .instr_rsrc1(instr_rsrc1), .instr_rsrc2(instr_rsrc2),
    .instr_imm(instr_imm), .instr_pc(instr_pc), .halted(halted)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_instr_count(perf_instr_count), .perf_stall_count(perf_stall_count)
`endif
  );

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .mem_req(mem_req_w), .mem_addr(mem_addr_w),
    .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w), .halt(halt_w),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
    .instr_opcode(instr_opcode_w), .instr_rdest(instr_rdest_w),
    .instr_rsrc1(instr_rsrc1_w), .instr_rsrc2(instr_rsrc2_w),
    .instr_imm(instr_imm_w), .instr_pc(instr_pc_w), .halted(halted_w)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_instr_count(perf_instr_count_w), .perf_stall_count(perf_stall_count_w)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; force_ack = 1'b0; ack_en = 1'b1; ack_lat = 0;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0]  = 8'hA0; mem[1]  = 8'h12; mem[2]  = 8'h00; mem[3]  = 8'h05;
    mem[4]  = 8'hB1; mem[5]  = 8'h23; mem[6]  = 8'h40; mem[7]  = 8'h07;
    mem[8]  = 8'hC2; mem[9]  = 8'h34; mem[10] = 8'h50; mem[11] = 8'h09;
    mem[64] = 8'h11; mem[65] = 8'h34; mem[66] = 8'h56; mem[67] = 8'h78;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; force_ack = 1'b0; ack_en = 1'b1; ack_lat = 0;
    step(); step();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b vld=%b hlt=%b exp 0 0 0", mem_req, instr_valid, halted);
    end
    checks++;
    if ({instr_opcode, instr_rdest, instr_rsrc1, instr_rsrc2, instr_imm, instr_pc} !== '0) begin
      errors++;
      $display("FAIL reset_fields got op=%h pc=%h imm=%h exp 0", instr_opcode, instr_pc, instr_imm);
    end
    checks++;
    if (mem_req_w !== 1'b0 || instr_valid_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_w got req=%b vld=%b exp 0 0", mem_req_w, instr_valid_w);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    checks++;
    if (perf_instr_count !== 32'd0 || perf_stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d %0d exp 0 0", perf_instr_count, perf_stall_count);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    instr_ready = 1'b1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL basic_first_req got req=%b addr=%h exp 1 0000", mem_req, mem_addr);
    end
    repeat (3) step();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %b exp 0", instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 8'hA0 || instr_rdest !== 4'h1 ||
        instr_rsrc1 !== 4'h2 || instr_rsrc2 !== 4'h0 || instr_imm !== 16'h0005) begin
      errors++;
      $display("FAIL basic_word got vld=%b op=%h rd=%h rs1=%h rs2=%h imm=%h exp 1 a0 1 2 0 0005",
               instr_valid, instr_opcode, instr_rdest, instr_rsrc1, instr_rsrc2, instr_imm);
    end
    checks++;
    if (instr_pc !== 16'h0000 || mem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL basic_pc got ipc=%h addr=%h exp 0000 0004", instr_pc, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_op [3];
    exp_op[0] = 8'hA0; exp_op[1] = 8'hB1; exp_op[2] = 8'hC2;
    do_reset();
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat (3) step();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap%0d got vld=%b exp 0", k, instr_valid);
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(4 * k) || instr_opcode !== exp_op[k]) begin
        errors++;
        $display("FAIL b2b_word%0d got vld=%b pc=%h op=%h exp 1 %h %h",
                 k, instr_valid, instr_pc, instr_opcode, 16'(4 * k), exp_op[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 8'hA0) begin
      errors++;
      $display("FAIL bp_first got vld=%b op=%h exp 1 a0", instr_valid, instr_opcode);
    end
    repeat (4) step();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_opcode !== 8'hA0 || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL bp_wait_slot got req=%b vld=%b op=%h pc=%h exp 0 1 a0 0000",
               mem_req, instr_valid, instr_opcode, instr_pc);
    end
    repeat (2) step();
    checks++;
    if (mem_req !== 1'b0 || instr_opcode !== 8'hA0 || instr_imm !== 16'h0005) begin
      errors++;
      $display("FAIL bp_stable got req=%b op=%h imm=%h exp 0 a0 0005", mem_req, instr_opcode, instr_imm);
    end
    instr_ready = 1'b1;
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_opcode !== 8'hB1 || instr_pc !== 16'h0004 || instr_imm !== 16'h4007) begin
      errors++;
      $display("FAIL bp_second got vld=%b op=%h pc=%h imm=%h exp 1 b1 0004 4007",
               instr_valid, instr_opcode, instr_pc, instr_imm);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0008) begin
      errors++;
      $display("FAIL bp_resume got req=%b addr=%h exp 1 0008", mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (6) step();
    redirect_valid = 1'b1; redirect_pc = 16'h0040; force_ack = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_req got %b exp 0", mem_req);
    end
    step();
    redirect_valid = 1'b0; force_ack = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL redir_next got vld=%b req=%b addr=%h exp 0 1 0040", instr_valid, mem_req, mem_addr);
    end
    instr_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instr_opcode !== 8'h11 ||
        instr_rdest !== 4'h3 || instr_rsrc1 !== 4'h4 || instr_imm !== 16'h5678) begin
      errors++;
      $display("FAIL redir_word got vld=%b pc=%h op=%h rd=%h rs1=%h imm=%h exp 1 0040 11 3 4 5678",
               instr_valid, instr_pc, instr_opcode, instr_rdest, instr_rsrc1, instr_imm);
    end
  endtask

  task automatic test_halt();
    int bad;
    do_reset();
    instr_ready = 1'b0;
    repeat (6) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b1 || mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_opcode !== 8'hA0) begin
      errors++;
      $display("FAIL halt_enter got hlt=%b req=%b vld=%b op=%h exp 1 0 1 a0",
               halted, mem_req, instr_valid, instr_opcode);
    end
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL halt_hold got req=%b vld=%b pc=%h exp 0 1 0000", mem_req, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_after got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF; exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req_w !== 1'b1 || mem_addr_w !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr%0d got req=%b addr=%h exp 1 %h", i, mem_req_w, mem_addr_w, exp_addr[i]);
      end
      step();
    end
    checks++;
    if (instr_valid_w !== 1'b1 || instr_pc_w !== 16'hFFFE || mem_addr_w !== 16'h0002 ||
        instr_opcode_w !== 8'hA4) begin
      errors++;
      $display("FAIL wrap_word got vld=%b pc=%h addr=%h op=%h exp 1 fffe 0002 a4",
               instr_valid_w, instr_pc_w, mem_addr_w, instr_opcode_w);
    end
  endtask

`ifdef FETCH_PERF_COUNTERS_EN
  task automatic test_perf();
    int pulses;
    int cyc;
    do_reset();
    instr_ready = 1'b1;
    ack_lat = 1;
    pulses = 0;
    cyc = 0;
    while (pulses < 3 && cyc < 200) begin
      step();
      cyc++;
      if (instr_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL perf_timeout got %0d words exp 3", pulses);
    end
    checks++;
    if (perf_instr_count !== 32'd3 || perf_stall_count !== 32'd12) begin
      errors++;
      $display("FAIL perf_counts got instr=%0d stall=%0d exp 3 12", perf_instr_count, perf_stall_count);
    end
  endtask
`endif

  initial begin
    load_mem();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
`ifdef FETCH_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
